pmod_i2s_rx: RTL and testbench

Deserializer for the codec ADC path: samples SDOUT1 against the BICK/LRCK pair produced by the clock-divider logic and presents one parallel stereo frame (left + right, signed 16-bit) per LRCK period. Sits between the codec pins and the sample-processing logic, mirroring the existing SDIN1 serializer. Everything runs in the 12 MHz CLK domain; BICK is treated as a data signal, never as a clock.

---
 rtl/pmod_i2s_pkg.sv | 24 ++
 rtl/pmod_i2s_rx_sync_edge.sv | 35 +++
 rtl/pmod_i2s_rx.sv | 162 ++++++++++++++++
 tb/tb_pmod_i2s_rx.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pmod_i2s_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pmod_i2s_pkg
// Brief   : Shared types for the codec I2S serializer/deserializer pair.
// Revision: 1.0  initial release
// ============================================================================
package pmod_i2s_pkg;

    // Bits per audio sample on the codec link.
    localparam int W_DEFAULT = 16;

    // Two's complement audio sample exchanged with the sample-processing logic.
    typedef logic signed [W_DEFAULT-1:0] sample_t;

    // Slot receiver states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SKIP  = 2'd1,
        SHIFT = 2'd2,
        FULL  = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/pmod_i2s_rx_sync_edge.sv
`default_nettype none
// ============================================================================
// Module  : sync_edge
// Brief   : Two-stage register chain on a CLK-synchronous level signal with
//           rise / fall / change strobes derived from the two stages.
// Revision: 1.0  initial release
// ============================================================================
module sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall,
    output logic change
);
    logic qq;

    // Input register followed by the history register used for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q  <= 1'b0;
            qq <= 1'b0;
        end else begin
            q  <= d;
            qq <= q;
        end
    end

    assign rise   = q & ~qq;
    assign fall   = ~q & qq;
    assign change = q ^ qq;

endmodule
`default_nettype wire

// File: rtl/pmod_i2s_rx.sv
`default_nettype none
// ============================================================================
// Module  : pmod_i2s_rx
// Brief   : Codec ADC deserializer. Samples SDOUT1 on detected BICK rises and
//           presents one left+right frame per LRCK period. BICK and LRCK are
//           treated as data in the CLK domain.
// Revision: 1.0  initial release
// ============================================================================
module pmod_i2s_rx
    import pmod_i2s_pkg::*;
#(
    parameter int W     = W_DEFAULT,
    parameter int DELAY = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         bick,
    input  logic         lrck,
    input  logic         sdout,
    output logic [W-1:0] sample_l,
    output logic [W-1:0] sample_r,
    output logic         valid,
    output logic         err
);
    localparam int            BW        = $clog2(W + 1);
    localparam logic [BW-1:0] BCNT_FULL = BW'(W);
    // Index of the last discarded rise; unused when DELAY is 0.
    localparam logic [7:0]    SKIP_LAST = 8'(DELAY - 1);

    logic bick_q, bick_rise, bick_fall, bick_chg;
    logic lrck_q, lrck_rise, lrck_fall, lrck_chg;
    logic sdout_q;
    logic unused_edges;

    state_t        state, state_n;
    logic [BW-1:0] bcnt, bcnt_n;
    logic [7:0]    skip_cnt, skip_n;
    logic [W-1:0]  shift_reg, shift_n;
    logic [W-1:0]  hold_l, hold_n;
    logic [W-1:0]  sl_n, sr_n;
    logic          chan, chan_n;
    logic          frame_ok, ok_n;
    logic          valid_n, err_n;

    sync_edge u_bick_sync (
        .clk    (clk),
        .rst    (rst),
        .d      (bick),
        .q      (bick_q),
        .rise   (bick_rise),
        .fall   (bick_fall),
        .change (bick_chg)
    );

    sync_edge u_lrck_sync (
        .clk    (clk),
        .rst    (rst),
        .d      (lrck),
        .q      (lrck_q),
        .rise   (lrck_rise),
        .fall   (lrck_fall),
        .change (lrck_chg)
    );

    assign unused_edges = bick_q ^ bick_fall ^ bick_chg ^ lrck_rise;

    // Data input register, aligned with the bick_q / lrck_q stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sdout_q <= 1'b0;
        else     sdout_q <= sdout;
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // Next-state and datapath update. An LRCK edge is applied first so that a
    // BICK rise in the same cycle is treated as the first rise of the new slot.
    always_comb begin
        state_n = state;
        bcnt_n  = bcnt;
        skip_n  = skip_cnt;
        shift_n = shift_reg;
        hold_n  = hold_l;
        chan_n  = chan;
        ok_n    = frame_ok;
        sl_n    = sample_l;
        sr_n    = sample_r;
        valid_n = 1'b0;
        err_n   = 1'b0;

        // IDLE only wakes on a falling LRCK so capture always starts left.
        if (lrck_chg && (state != IDLE || lrck_fall)) begin
            if (state == SKIP || (state == SHIFT && bcnt < BCNT_FULL)) begin
                err_n = 1'b1;
                ok_n  = 1'b0;
            end
            chan_n  = lrck_q;
            bcnt_n  = '0;
            shift_n = '0;
            skip_n  = '0;
            state_n = (DELAY == 0) ? SHIFT : SKIP;
        end

        if (bick_rise) begin
            case (state_n)
                SKIP: begin
                    if (skip_n == SKIP_LAST) state_n = SHIFT;
                    else                     skip_n  = skip_n + 1'b1;
                end
                SHIFT: begin
                    shift_n = {shift_n[W-2:0], sdout_q};
                    bcnt_n  = bcnt_n + 1'b1;
                    if (bcnt_n == BCNT_FULL) begin
                        state_n = FULL;
                        if (!chan_n) begin
                            hold_n = shift_n;
                            ok_n   = 1'b1;
                        end else if (ok_n) begin
                            sl_n    = hold_l;
                            sr_n    = shift_n;
                            valid_n = 1'b1;
                            ok_n    = 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bcnt      <= '0;
            skip_cnt  <= '0;
            shift_reg <= '0;
            hold_l    <= '0;
            chan      <= 1'b0;
            frame_ok  <= 1'b0;
            sample_l  <= '0;
            sample_r  <= '0;
            valid     <= 1'b0;
            err       <= 1'b0;
        end else begin
            bcnt      <= bcnt_n;
            skip_cnt  <= skip_n;
            shift_reg <= shift_n;
            hold_l    <= hold_n;
            chan      <= chan_n;
            frame_ok  <= ok_n;
            sample_l  <= sl_n;
            sample_r  <= sr_n;
            valid     <= valid_n;
            err       <= err_n;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pmod_i2s_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_pmod_i2s_rx
// Brief   : Bench for pmod_i2s_rx. Two receivers (I2S and left-justified
//           framing) watch the same codec pins; a slot-level model predicts
//           every valid/err pulse and held sample per CLK.
// Revision: 1.0  initial release
// ============================================================================
module tb_pmod_i2s_rx;

    logic clk = 1'b0;
    logic rst, bick, lrck, sdout;
    wire [1:0]       v, e;
    wire [1:0][15:0] sl, sr;

    always #5 clk = ~clk;

    // Index 0: I2S framing (DELAY=1). Index 1: left-justified (DELAY=0).
    pmod_i2s_rx #(.W(16), .DELAY(1)) u_i2s (
        .clk(clk), .rst(rst), .bick(bick), .lrck(lrck), .sdout(sdout),
        .sample_l(sl[0]), .sample_r(sr[0]), .valid(v[0]), .err(e[0])
    );

    pmod_i2s_rx #(.W(16), .DELAY(0)) u_lj (
        .clk(clk), .rst(rst), .bick(bick), .lrck(lrck), .sdout(sdout),
        .sample_l(sl[1]), .sample_r(sr[1]), .valid(v[1]), .err(e[1])
    );

    int errors = 0;
    int checks = 0;
    int step   = 0;
    int dly [2] = '{1, 0};

    // Expected pulses keyed by step*2 + instance.
    bit          exp_v [int];
    bit          exp_e [int];
    logic [15:0] exp_l [int];
    logic [15:0] exp_r [int];

    // Slot-level model state per instance.
    bit          act [2];
    bit          fok [2];
    bit          chc [2];
    logic [15:0] hold [2];
    logic [15:0] acc [2];
    int          rc [2];

    // Compare-side state.
    logic [15:0] ml [2];
    logic [15:0] mr [2];
    int          vcnt [2];
    int          ecnt [2];

    int s_v0, s_v1, s_e0, s_e1;
    logic [15:0] ra, rb;

    // Per-cycle comparison of both receivers against the model.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            int key;
            bit ev, ee;
            key = step * 2 + i;
            ev  = 1'b0;
            ee  = 1'b0;
            if (rst) begin
                ml[i] = 16'h0;
                mr[i] = 16'h0;
            end else begin
                ev = exp_v.exists(key);
                ee = exp_e.exists(key);
                if (ev) begin
                    ml[i] = exp_l[key];
                    mr[i] = exp_r[key];
                end
            end
            checks++;
            if (v[i] !== ev || e[i] !== ee || sl[i] !== ml[i] || sr[i] !== mr[i]) begin
                errors++;
                $display("FAIL cycle dut%0d step=%0d valid=%b/%b err=%b/%b left=%h/%h right=%h/%h (got/want)",
                         i, step, v[i], ev, e[i], ee, sl[i], ml[i], sr[i], mr[i]);
            end
            if (v[i] === 1'b1) vcnt[i]++;
            if (e[i] === 1'b1) ecnt[i]++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        step++;
    endtask

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    // LRCK pin changed this step: close the previous slot, open the new one.
    function automatic void model_edge(input bit ch);
        for (int i = 0; i < 2; i++) begin
            if (!act[i]) begin
                if (!ch) begin
                    act[i] = 1'b1;
                    rc[i]  = 0;
                    acc[i] = 16'h0;
                    chc[i] = ch;
                end
            end else begin
                if (rc[i] < dly[i] + 16) begin
                    exp_e[(step + 2) * 2 + i] = 1'b1;
                    fok[i] = 1'b0;
                end
                rc[i]  = 0;
                acc[i] = 16'h0;
                chc[i] = ch;
            end
        end
    endfunction

    // BICK pin rose this step: rises DELAY..DELAY+15 of a slot carry the sample.
    function automatic void model_rise();
        for (int i = 0; i < 2; i++) begin
            if (act[i]) begin
                if (rc[i] >= dly[i] && rc[i] < dly[i] + 16)
                    acc[i] = {acc[i][14:0], sdout};
                if (rc[i] == dly[i] + 15) begin
                    if (!chc[i]) begin
                        hold[i] = acc[i];
                        fok[i]  = 1'b1;
                    end else if (fok[i]) begin
                        int k;
                        k = (step + 2) * 2 + i;
                        exp_v[k] = 1'b1;
                        exp_l[k] = hold[i];
                        exp_r[k] = acc[i];
                        fok[i]   = 1'b0;
                    end
                end
                rc[i]++;
            end
        end
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            act[i]  = 1'b0;
            fok[i]  = 1'b0;
            hold[i] = 16'h0;
            acc[i]  = 16'h0;
            rc[i]   = 0;
        end
        exp_v.delete();
        exp_e.delete();
        exp_l.delete();
        exp_r.delete();
    endfunction

    // One slot of nper BICK periods; bit of period k is val MSB-first from txd.
    // junk: 0 or 1 = constant filler, 2 = random filler.
    task automatic send_slot(input bit ch, input int nper, input logic [15:0] val,
                             input int txd, input int junk);
        for (int k = 0; k < nper; k++) begin
            int lo, hi;
            lo = $urandom_range(2, 3);
            hi = $urandom_range(2, 3);
            tick();
            bick = 1'b0;
            if (k >= txd && k < txd + 16) sdout = val[15 - (k - txd)];
            else if (junk == 2)           sdout = 1'($urandom);
            else                          sdout = junk[0];
            if (k == 0 && lrck != ch) begin
                lrck = ch;
                model_edge(ch);
            end
            repeat (lo - 1) tick();
            tick();
            bick = 1'b1;
            model_rise();
            repeat (hi - 1) tick();
        end
    endtask

    task automatic frame(input logic [15:0] l, input logic [15:0] r, input int txd, input int junk);
        send_slot(1'b0, 32, l, txd, junk);
        send_slot(1'b1, 32, r, txd, junk);
    endtask

    task automatic snap();
        s_v0 = vcnt[0]; s_v1 = vcnt[1];
        s_e0 = ecnt[0]; s_e1 = ecnt[1];
    endtask

    initial begin
        rst = 1'b1; lrck = 1'b1; bick = 1'b0; sdout = 1'b0;
        model_reset();
        repeat (4) tick();
        chk("reset_l", sl[0], 16'h0);
        chk("reset_r", sr[0], 16'h0);
        chk("reset_valid_err", {14'h0, v[0], e[0]}, 16'h0);

        // Startup mid right slot, then nominal I2S frames.
        snap();
        rst = 1'b0;
        send_slot(1'b1, 20, 16'h5A5A, 1, 2);
        frame(16'h8001, 16'h7FFE, 1, 2);
        frame(16'h8001, 16'h7FFE, 1, 2);
        repeat (3) tick();
        chk("nominal_l", sl[0], 16'h8001);
        chk("nominal_r", sr[0], 16'h7FFE);
        chk("nominal_valid_count", 16'(vcnt[0] - s_v0), 16'd2);
        chk("startup_err_count", 16'(ecnt[0] - s_e0 + ecnt[1] - s_e1), 16'd0);

        // Left-justified data seen by both framings.
        frame(16'h1234, 16'hABCD, 0, 0);
        repeat (3) tick();
        chk("lj_l", sl[1], 16'h1234);
        chk("lj_r", sr[1], 16'hABCD);
        chk("lj_misset_l", sl[0], 16'h2468);
        chk("lj_misset_r", sr[0], 16'h579A);

        // Short left slot.
        snap();
        ra = 16'($urandom);
        rb = 16'($urandom);
        send_slot(1'b0, 10, 16'hFFFF, 1, 2);
        send_slot(1'b1, 32, 16'h3C3C, 1, 2);
        frame(ra, rb, 1, 2);
        repeat (3) tick();
        chk("short_err_count", 16'(ecnt[0] - s_e0), 16'd1);
        chk("short_valid_count", 16'(vcnt[0] - s_v0), 16'd1);
        chk("short_next_l", sl[0], ra);
        chk("short_next_r", sr[0], rb);

        // Reset after 8 right-channel bits.
        send_slot(1'b0, 32, 16'h1111, 1, 2);
        send_slot(1'b1, 8, 16'h2222, 1, 2);
        tick();
        rst = 1'b1;
        model_reset();
        #1;
        chk("midrst_l0", sl[0], 16'h0);
        chk("midrst_r0", sr[0], 16'h0);
        chk("midrst_l1", sl[1], 16'h0);
        chk("midrst_r1", sr[1], 16'h0);
        chk("midrst_flags", {12'h0, v, e}, 16'h0);
        repeat (3) tick();
        rst = 1'b0;
        snap();
        send_slot(1'b1, 24, 16'h2222, 1, 2);
        frame(16'h00FF, 16'hFF00, 1, 2);
        repeat (3) tick();
        chk("postrst_valid_count", 16'(vcnt[0] - s_v0), 16'd1);
        chk("postrst_l", sl[0], 16'h00FF);
        chk("postrst_r", sr[0], 16'hFF00);

        // Long slots with trailing ones.
        frame(16'h0F0F, 16'hF0F0, 1, 1);
        repeat (3) tick();
        chk("long_l", sl[0], 16'h0F0F);
        chk("long_r", sr[0], 16'hF0F0);

        // Random frames with random slot lengths and framing.
        for (int f = 0; f < 20; f++) begin
            int txd;
            txd = $urandom_range(0, 1);
            for (int c = 0; c < 2; c++) begin
                int pick, n;
                pick = $urandom_range(0, 7);
                n = (pick == 0) ? 12 : (pick == 1) ? 16 : (pick == 2) ? 17 : (pick < 5) ? 24 : 32;
                send_slot(c[0], n, 16'($urandom), txd, 2);
            end
        end
        repeat (6) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
